// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
//   rx_state_e : receiver FSM states
//   PAR_*      : meaning of the PAR_TYP input
//   START_BIT / STOP_BIT : line levels of the framing bits
package uart_pkg;
  localparam int   DATA_WIDTH_DEF = 8;
  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;
endpackage

// File: rtl/uart_rx_sampler.sv
// Bit-period timing and 2-of-3 majority sampling for the UART receiver.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   rx_in          : serial line (already synchronised)
//   prescale       : clocks per bit (P)
//   clr_i          : force edge counter and samples to 0 (FSM heading to IDLE)
//   load_i         : start of frame; edge counter loads 1 (start sample = edge 0)
//   bit_o          : majority of the three mid-bit samples
//   bit_done_o     : edge_cnt == P-1 (last clock of the bit period)
//   sample_done_o  : edge_cnt == H+2 (bit_o is valid)
module uart_rx_sampler #(
  parameter int PRESC_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_in,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               clr_i,
  input  logic               load_i,
  output logic               bit_o,
  output logic               bit_done_o,
  output logic               sample_done_o
);
  logic [PRESC_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [2:0]         smp_q, smp_d;
  logic [PRESC_W-1:0] p_last;
  logic [PRESC_W:0]   half, cnt_x;

  // One extra bit on the mid-bit compares so H+2 cannot alias for any P.
  assign p_last = prescale - PRESC_W'(1);
  assign half   = {2'b00, prescale[PRESC_W-1:1]};
  assign cnt_x  = {1'b0, edge_cnt_q};

  assign bit_done_o    = (edge_cnt_q == p_last);
  assign sample_done_o = (cnt_x == half + (PRESC_W+1)'(2));
  assign bit_o         = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);

  always_comb begin
    edge_cnt_d = edge_cnt_q;
    smp_d      = smp_q;
    if (clr_i) begin
      edge_cnt_d = '0;
      smp_d      = '0;
    end else if (load_i) begin
      edge_cnt_d = PRESC_W'(1);
    end else begin
      // Equality wrap plus natural overflow: the counter always cycles,
      // even for unsupported prescale values.
      edge_cnt_d = bit_done_o ? '0 : edge_cnt_q + PRESC_W'(1);
      if (cnt_x == half - (PRESC_W+1)'(1)) smp_d[0] = rx_in;
      if (cnt_x == half)                   smp_d[1] = rx_in;
      if (cnt_x == half + (PRESC_W+1)'(1)) smp_d[2] = rx_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt_q <= '0;
      smp_q      <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      smp_q      <= smp_d;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, DATA_WIDTH data bits LSB-first, optional parity, stop.
// Ports:
//   CLK, RST   : clock (= oversampling clock), synchronous active-high reset
//   RX_IN      : serial line, idles high
//   PRESCALE   : clocks per bit (8/16/32), change only while idle
//   PAR_EN     : parity bit present; PAR_TYP 0 = even, 1 = odd
//   P_DATA     : last good byte, held between frames
//   DATA_VALID : 1-cycle pulse when P_DATA updates
//   PAR_ERR    : 1-cycle pulse, parity mismatch (frame dropped)
//   STP_ERR    : 1-cycle pulse, stop bit low (frame dropped, beats PAR_ERR)
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PRESC_W    = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESC_W-1:0]    PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);
  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

  rx_state_e             state_q, state_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic par_en_q, par_en_d, par_typ_q, par_typ_d, par_fail_q, par_fail_d;
  logic dv_q, dv_d, pe_q, pe_d, se_q, se_d;
  logic rx_bit, bit_done, sample_done;

  uart_rx_sampler #(.PRESC_W(PRESC_W)) u_sampler (
    .clk           (CLK),
    .rst           (RST),
    .rx_in         (RX_IN),
    .prescale      (PRESCALE),
    .clr_i         (state_d == IDLE),
    .load_i        (state_q == IDLE),
    .bit_o         (rx_bit),
    .bit_done_o    (bit_done),
    .sample_done_o (sample_done)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    p_data_d   = p_data_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    par_fail_d = par_fail_q;
    dv_d       = 1'b0;
    pe_d       = 1'b0;
    se_d       = 1'b0;
    case (state_q)
      IDLE: if (RX_IN == START_BIT) begin
        state_d    = START;
        par_en_d   = PAR_EN;
        par_typ_d  = PAR_TYP;
        par_fail_d = 1'b0;
        bit_cnt_d  = '0;
      end
      START: begin
        if (sample_done && rx_bit != START_BIT) state_d = IDLE;  // glitch
        else if (bit_done) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (sample_done) shreg_d = {rx_bit, shreg_q[DATA_WIDTH-1:1]};
        if (bit_done) begin
          if (bit_cnt_q == LAST_BIT) state_d = par_en_q ? PARITY : STOP;
          else bit_cnt_d = bit_cnt_q + BCW'(1);
        end
      end
      PARITY: begin
        if (sample_done) par_fail_d = (rx_bit != (^shreg_q ^ (par_typ_q != PAR_EVEN)));
        if (bit_done) state_d = STOP;
      end
      STOP: begin
        // Leave at the stop sample point so a back-to-back start edge is caught.
        if (sample_done) begin
          state_d = IDLE;
          if (rx_bit != STOP_BIT) se_d = 1'b1;
          else if (par_fail_q)    pe_d = 1'b1;
          else begin
            p_data_d = shreg_q;
            dv_d     = 1'b1;
          end
        end else if (bit_done) begin
          state_d = IDLE;  // only reachable with unsupported prescale values
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      p_data_q   <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_fail_q <= 1'b0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      se_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      p_data_q   <= p_data_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      par_fail_q <= par_fail_d;
      dv_q       <= dv_d;
      pe_q       <= pe_d;
      se_q       <= se_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign DATA_VALID = dv_q;
  assign PAR_ERR    = pe_q;
  assign STP_ERR    = se_q;
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver; the downstream consumer of the UART transmitter's TX_OUT line.
- Recovers frames of the form start(0), 8 data bits LSB-first, optional parity, stop(1).
- Oversamples the line at PRESCALE clocks per bit and decides each bit by 2-of-3 majority vote.
- Delivers the byte on a one-cycle DATA_VALID strobe, or flags a parity or stop error instead.

Parameters:
- DATA_WIDTH, 8, payload bits per frame.
- PRESC_W, 6, width of the PRESCALE port.

Ports:
- CLK  in  1  system clock, equal to the oversampling clock.
- RST  in  1  synchronous, active-high reset.
- RX_IN  in  1  serial line; idles high; already synchronised to CLK.
- PRESCALE  in  PRESC_W  clocks per bit; legal values 8, 16, 32; change only while idle.
- PAR_EN  in  1  1 = a parity bit follows the data bits.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity.
- P_DATA  out  DATA_WIDTH  last good byte; holds its value between frames.
- DATA_VALID  out  1  one-cycle pulse when P_DATA updates.
- PAR_ERR  out  1  one-cycle pulse: parity mismatch, frame discarded.
- STP_ERR  out  1  one-cycle pulse: stop bit sampled 0, frame discarded.

Behaviour:
- Reset, sampled at a rising CLK edge with RST=1:
  - P_DATA=0; DATA_VALID, PAR_ERR and STP_ERR all 0.
  - State IDLE; edge_cnt, bit_cnt and sample registers all 0.
  - Reset mid-frame aborts the frame with no strobe.
- Let P = PRESCALE and H = P/2.
- Edge counter:
  - edge_cnt runs 0..P-1 within each bit period and wraps.
  - Samples are captured at edge_cnt = H-1, H and H+1.
  - The bit value is the majority of the three, resolved at edge_cnt = H+2.
- State IDLE:
  - RX_IN=0 sampled at edge t0 → state START, edge_cnt←1 (that sample counts as edge 0).
  - PAR_EN and PAR_TYP are latched at t0 and used for the whole frame.
- State START:
  - Resolved value 1 → false start (glitch); return to IDLE at resolution, no strobe.
  - Resolved value 0 → continue; at edge_cnt = P-1 go to DATA, bit_cnt←0.
- State DATA:
  - Each resolved bit shifts into the MSB of the shift register (LSB arrives first).
  - After bit_cnt = DATA_WIDTH-1 completes (edge_cnt = P-1), go to PARITY if the latched PAR_EN=1, else STOP.
- State PARITY:
  - Expected bit = XOR of the data bits, inverted when odd parity is selected.
  - A mismatch sets an internal par_fail flag; at edge_cnt = P-1 go to STOP.
- State STOP, at resolution (edge_cnt = H+2):
  - Go to IDLE immediately; the rest of the stop bit is not waited out, so the receiver resynchronises for back-to-back frames.
  - Strobes and P_DATA update are registered at that edge and visible for exactly one cycle.
  - Stop resolved 0 → STP_ERR=1, even if parity also failed (STP_ERR takes priority).
  - Otherwise par_fail → PAR_ERR=1.
  - Otherwise P_DATA ← shift register and DATA_VALID=1.
  - On any error, P_DATA keeps its previous value.
- Latency:
  - Stop bit index n = 9 without parity, 10 with parity.
  - Strobe is high in the cycle after edge t0 + n·P + H + 2.
  - Example: P=8, no parity → t0+78; P=8, parity → t0+86.
- Back-to-back frames: the falling edge of the next start bit may arrive any time after the stop sample point; it is detected from IDLE with at most one cycle of phase error.
- Line held low indefinitely (break condition):
  - STP_ERR pulses once, then the FSM restarts a frame from IDLE.
  - No hang; no DATA_VALID is produced.
- PRESCALE values other than 8, 16 or 32 are unsupported; behaviour for them is undefined but must not lock the FSM.

Decomposition:
- uart_pkg holds:
  - state enum {IDLE, START, DATA, PARITY, STOP};
  - constants PAR_EVEN=0, PAR_ODD=1;
  - START_BIT=0, STOP_BIT=1, and DATA_WIDTH default.
- Sub-module uart_rx_sampler:
  - contains edge_cnt, the three-sample capture and the majority vote;
  - outputs the resolved bit, a bit_done strobe (edge_cnt = P-1) and a sample_done strobe (edge_cnt = H+2).
- The top level holds the FSM, bit counter, shift register, parity check and output registers.

Test Plan:
- Frame 11'b1_1_10101011_0, P=8, PAR_EN=1, PAR_TYP=even → P_DATA=8'hAB, DATA_VALID pulse at t0+86, no error strobes.
- Back-to-back frames with no idle gap: 8'hAB even-parity frame, then 11'b1_0_01001100_0 odd parity → two DATA_VALID pulses, P_DATA=8'hAB then 8'h4C.
- PAR_EN=0, frame 10'b1_00001111_0 at P=16 and P=32 → P_DATA=8'h0F at t0+9·P+H+2.
- Frame for 8'h83, odd parity, parity bit flipped to 1 → PAR_ERR pulse; no DATA_VALID; P_DATA keeps its prior value.
- Stop bit forced to 0 on 8'h5A (also with a bad parity bit) → STP_ERR only; P_DATA unchanged.
- Robustness, P=8:
  - a 2-clock low glitch on idle RX_IN → no strobe, FSM back in IDLE;
  - RST=1 in the middle of the data bits, then a clean 8'hC3 frame → outputs read reset values, then 8'hC3 is received correctly.
